// File: rtl/gon_pkg.sv
// Shared definitions for the global output network (PE array -> GLB gather).
package gon_pkg;

   // Default array geometry and word widths.
   localparam int unsigned DefRows      = 6;
   localparam int unsigned DefCols      = 8;
   localparam int unsigned DefDataW     = 32;
   localparam int unsigned DefXidW      = 5;
   localparam int unsigned DefYidW      = 4;
   localparam int unsigned DefFifoDepth = 4;

   typedef logic [DefXidW-1:0]  xid_t;
   typedef logic [DefYidW-1:0]  yid_t;
   typedef logic [DefDataW-1:0] data_t;

   // Index/pointer width for a structure with 'depth' entries; never below 1 bit.
   function automatic int unsigned ptr_w(int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/gon_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, wrapping.
module gon_rr_arbiter
   import gon_pkg::*;
#(
   parameter int unsigned N    = 4,
   localparam int unsigned IdxW = ptr_w(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [IdxW-1:0] grant_idx
);

   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [N-1:0]    lo_mask, masked, pick;
   logic [IdxW-1:0] idx_or [N+1];

   // Requests below rr_ptr are only considered when nothing at/after it is pending.
   always_comb begin
      lo_mask = (N'(1) << rr_ptr_q) - N'(1);
      masked  = req & ~lo_mask;
      pick    = (|masked) ? masked : req;
      grant   = pick & (~pick + N'(1));
   end

   // One-hot to binary encoder as an OR chain.
   assign idx_or[0] = '0;
   for (genvar i = 0; i < N; i++) begin : g_enc
      assign idx_or[i+1] = idx_or[i] | (grant[i] ? IdxW'(i) : '0);
   end
   assign grant_idx = idx_or[N];

   // Pointer moves just past the winner on an accepted grant.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (flush) begin
         rr_ptr_d = '0;
      end else if (advance) begin
         rr_ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + IdxW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/gon_rr_buffered.sv
// Gather network: ID-matched PEs arbitrated round-robin into an output FIFO to the GLB.
module gon_rr_buffered
   import gon_pkg::*;
#(
   parameter int unsigned ROWS       = DefRows,
   parameter int unsigned COLS       = DefCols,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned XID_W      = DefXidW,
   parameter int unsigned YID_W      = DefYidW,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [XID_W-1:0]              tag_X,
   input  logic [YID_W-1:0]              tag_Y,
   input  logic                          set_XID,
   input  logic [XID_W-1:0]              XID_scan_in,
   input  logic                          set_YID,
   input  logic [YID_W-1:0]              YID_scan_in,
   input  logic [ROWS*COLS-1:0]          PE_valid,
   output logic [ROWS*COLS-1:0]          PE_ready,
   input  logic [DATA_W*ROWS*COLS-1:0]   PE_data,
   output logic                          GON_valid,
   input  logic                          GON_ready,
   output logic [DATA_W-1:0]             GON_data,
   output logic [15:0]                   beat_cnt
);

   localparam int unsigned N    = ROWS * COLS;
   localparam int unsigned IdxW = ptr_w(N);
   localparam int unsigned PtrW = ptr_w(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic [N-1:0][XID_W-1:0]    xid_q;
   logic [ROWS-1:0][YID_W-1:0] yid_q;
   logic [N-1:0][DATA_W-1:0]   pe_word;

   logic [N-1:0]    elig;
   logic [N-1:0]    grant;
   logic [IdxW-1:0] grant_idx;
   logic            full, push, pop;
   logic [DATA_W-1:0] push_data;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [15:0]       beat_q, beat_d;

   // ID scan chains: shifting the flat vector up one field moves xid[k-1] into xid[k].
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xid_q <= '0;
         yid_q <= '0;
      end else begin
         if (set_XID) xid_q <= (xid_q << XID_W) | (N*XID_W)'(XID_scan_in);
         if (set_YID) yid_q <= (yid_q << YID_W) | (ROWS*YID_W)'(YID_scan_in);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_match
      assign elig[i] = PE_valid[i] & (xid_q[i] == tag_X) & (yid_q[i/COLS] == tag_Y);
   end

   gon_rr_arbiter #(
      .N (N)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req       (elig),
      .advance   (push),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign pe_word   = PE_data;
   assign push_data = pe_word[grant_idx];

   // Ready depends only on registered occupancy, never on GON_ready.
   always_comb begin
      full      = (count_q == CntW'(FIFO_DEPTH));
      PE_ready  = grant & {N{~full & ~flush}};
      push      = (|grant) & ~full & ~flush;
      GON_valid = (count_q != '0);
      pop       = GON_valid & GON_ready & ~flush;
      GON_data  = GON_valid ? mem_q[rd_ptr_q] : '0;
      beat_cnt  = beat_q;
   end

   // FIFO and beat counter next state; flush discards any push or pop in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      beat_d   = beat_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         beat_d   = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
         if (pop && beat_q != 16'hFFFF) beat_d = beat_q + 16'd1;
      end
   end

   // FIFO control and beat counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         beat_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         beat_q   <= beat_d;
      end
   end

   // Storage needs no reset: it is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: tb/tb_gon_rr_buffered.sv
// Self-checking bench for gon_rr_buffered in a 2x2 configuration.
module tb_gon_rr_buffered;

   localparam int R = 2, C = 2, N = 4, DW = 32, XW = 5, YW = 4, FD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic          flush = 1'b0;
   logic [XW-1:0] tag_x = '0;
   logic [YW-1:0] tag_y = '0;
   logic          set_xid = 1'b0, set_yid = 1'b0;
   logic [XW-1:0] xid_in = '0;
   logic [YW-1:0] yid_in = '0;
   logic [N-1:0]  pe_valid = '0;
   logic [N-1:0]  pe_ready;
   logic [DW*N-1:0] pe_data = '0;
   logic          gon_valid;
   logic          gon_ready = 1'b0;
   logic [DW-1:0] gon_data;
   logic [15:0]   beat_cnt;

   gon_rr_buffered #(
      .ROWS(R), .COLS(C), .DATA_W(DW), .XID_W(XW), .YID_W(YW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst_n), .flush(flush), .tag_X(tag_x), .tag_Y(tag_y),
      .set_XID(set_xid), .XID_scan_in(xid_in), .set_YID(set_yid), .YID_scan_in(yid_in),
      .PE_valid(pe_valid), .PE_ready(pe_ready), .PE_data(pe_data),
      .GON_valid(gon_valid), .GON_ready(gon_ready), .GON_data(gon_data), .beat_cnt(beat_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural reference: ID arrays, a queue for the FIFO, an integer RR pointer.
   int          m_xid [N];
   int          m_yid [R];
   logic [31:0] m_q [$];
   int          m_rr;
   int          m_beat;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_xid[i]) m_xid[i] = 0;
      foreach (m_yid[i]) m_yid[i] = 0;
      m_q.delete();
      m_rr   = 0;
      m_beat = 0;
   endtask

   function automatic int m_pick();
      for (int off = 0; off < N; off++) begin
         int idx = (m_rr + off) % N;
         if (pe_valid[idx] && m_xid[idx] == int'(tag_x) && m_yid[idx / C] == int'(tag_y))
            return idx;
      end
      return -1;
   endfunction

   task automatic check_model(input string nm);
      int g = m_pick();
      logic [3:0] er = '0;
      if (g >= 0 && m_q.size() < FD && !flush) er = 4'(32'd1 << g);
      chk({nm, " ready"}, 64'(pe_ready), 64'(er));
      chk({nm, " gvalid"}, 64'(gon_valid), 64'(m_q.size() != 0));
      chk({nm, " gdata"}, 64'(gon_data), 64'((m_q.size() != 0) ? m_q[0] : 32'h0));
      chk({nm, " beat"}, 64'(beat_cnt), 64'(m_beat));
   endtask

   task automatic model_update();
      int g = m_pick();
      bit acc  = (g >= 0) && (m_q.size() < FD) && !flush;
      bit popv = (m_q.size() != 0) && gon_ready && !flush;
      if (flush) begin
         m_q.delete();
         m_beat = 0;
         m_rr   = 0;
      end else begin
         if (popv) begin
            void'(m_q.pop_front());
            if (m_beat < 65535) m_beat++;
         end
         if (acc) begin
            m_q.push_back(pe_data[g*DW +: DW]);
            m_rr = (g + 1) % N;
         end
      end
      if (set_xid) begin
         for (int k = N - 1; k > 0; k--) m_xid[k] = m_xid[k-1];
         m_xid[0] = int'(xid_in);
      end
      if (set_yid) begin
         for (int k = R - 1; k > 0; k--) m_yid[k] = m_yid[k-1];
         m_yid[0] = int'(yid_in);
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic scan_ids(input int xv, input int yv);
      pe_valid = '0;
      for (int k = 0; k < N; k++) begin
         set_xid = 1'b1; xid_in = XW'(xv);
         set_yid = (k < R); yid_in = YW'(yv);
         step();
      end
      set_xid = 1'b0; set_yid = 1'b0;
   endtask

   task automatic flush_cycle();
      flush = 1'b1;
      #1;
      chk("flush ready", 64'(pe_ready), 64'(0));
      step();
      flush = 1'b0;
   endtask

   typedef struct {
      logic sx; logic [XW-1:0] xi; logic sy; logic [YW-1:0] yi;
      logic [XW-1:0] tx; logic [YW-1:0] ty; logic [N-1:0] v; logic gr;
      logic [N-1:0] e_rdy; logic e_gv; logic [DW-1:0] e_gd;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      tbl[0] = '{1'b1, 5'd3, 1'b1, 4'd1, 5'd31, 4'd15, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 5'd2, 1'b1, 4'd0, 5'd31, 4'd15, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 5'd1, 1'b0, 4'd0, 5'd31, 4'd15, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
      tbl[3] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'd31, 4'd15, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
      tbl[4] = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd3,  4'd1,  4'hF, 1'b0, 4'h8, 1'b0, 32'h0};
      tbl[5] = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd3,  4'd1,  4'h0, 1'b1, 4'h0, 1'b1, 32'hD000_0003};
      tbl[6] = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd3,  4'd1,  4'h0, 1'b0, 4'h0, 1'b0, 32'h0};
      tbl[7] = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd0,  4'd0,  4'hF, 1'b0, 4'h1, 1'b0, 32'h0};
      tbl[8] = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd1,  4'd0,  4'hF, 1'b1, 4'h2, 1'b1, 32'hD000_0000};
      tbl[9] = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd1,  4'd0,  4'h0, 1'b1, 4'h0, 1'b1, 32'hD000_0001};

      // Reset state
      model_reset();
      #2 rst_n = 1'b0;
      #3;
      chk("reset gvalid", 64'(gon_valid), 64'(0));
      chk("reset ready", 64'(pe_ready), 64'(0));
      chk("reset gdata", 64'(gon_data), 64'(0));
      chk("reset beat", 64'(beat_cnt), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // ID scan and single-hit table
      for (int i = 0; i < N; i++) pe_data[i*DW +: DW] = 32'hD000_0000 + i;
      foreach (tbl[i]) begin
         set_xid = tbl[i].sx; xid_in = tbl[i].xi; set_yid = tbl[i].sy; yid_in = tbl[i].yi;
         tag_x = tbl[i].tx; tag_y = tbl[i].ty; pe_valid = tbl[i].v; gon_ready = tbl[i].gr;
         #1;
         chk($sformatf("tbl%0d ready", i), 64'(pe_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d gvalid", i), 64'(gon_valid), 64'(tbl[i].e_gv));
         chk($sformatf("tbl%0d gdata", i), 64'(gon_data), 64'(tbl[i].e_gd));
         step();
      end
      pe_valid = '0; gon_ready = 1'b0;

      // Multi-match round robin: every PE matches, GLB always ready
      scan_ids(5, 0);
      gon_ready = 1'b1;
      flush_cycle();
      tag_x = 5'd5; tag_y = 4'd0; pe_valid = 4'hF; gon_ready = 1'b1;
      pe_data = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr%0d ready", k), 64'(pe_ready), 64'(4'(32'd1 << (k % 4))));
         if (k > 0)
            chk($sformatf("rr%0d gdata", k), 64'(gon_data),
                64'(pe_data[((k - 1) % 4)*DW +: DW]));
         check_model("rr");
         step();
      end

      // Back-pressure: one eligible PE, GLB stalled
      pe_valid = '0; gon_ready = 1'b0;
      flush_cycle();
      pe_valid = 4'b0010;
      #1;
      acc = 0;
      for (int k = 0; k < 7; k++) begin
         if (pe_ready[1]) acc++;
         check_model("bp");
         pe_data[1*DW +: DW] = $urandom;
         step();
      end
      chk("bp accepts", 64'(acc), 64'(4));
      chk("bp full ready", 64'(pe_ready), 64'(0));
      gon_ready = 1'b1;
      #1;
      chk("bp pop-cycle ready", 64'(pe_ready), 64'(0));
      chk("bp pop-cycle gvalid", 64'(gon_valid), 64'(1));
      step();
      gon_ready = 1'b0;
      #1;
      chk("bp freed ready", 64'(pe_ready), 64'(4'b0010));
      step();
      chk("bp refull ready", 64'(pe_ready), 64'(0));
      check_model("bp end");

      // Simultaneous push and pop at count 2
      pe_valid = '0;
      flush_cycle();
      pe_valid = 4'b0001; gon_ready = 1'b0;
      pe_data[0 +: DW] = 32'h0000_0011; #1; step();
      pe_data[0 +: DW] = 32'h0000_0022; #1; step();
      pe_data[0 +: DW] = 32'h0000_0033; gon_ready = 1'b1;
      #1;
      chk("pp ready", 64'(pe_ready), 64'(4'b0001));
      chk("pp head", 64'(gon_data), 64'(32'h11));
      step();
      pe_valid = '0;
      #1;
      chk("pp drain0", 64'(gon_data), 64'(32'h22));
      step();
      chk("pp drain1", 64'(gon_data), 64'(32'h33));
      step();
      chk("pp drained", 64'(gon_valid), 64'(0));
      check_model("pp end");

      // Flush with 3 words buffered and beat_cnt at 7
      flush_cycle();
      pe_valid = 4'b0001; gon_ready = 1'b1;
      for (int k = 0; k < 20 && m_beat < 7; k++) begin
         pe_data[0 +: DW] = $urandom;
         #1; check_model("fl fill"); step();
      end
      gon_ready = 1'b0;
      for (int k = 0; k < 10 && m_q.size() < 3; k++) begin
         pe_data[0 +: DW] = $urandom;
         #1; check_model("fl load"); step();
      end
      pe_valid = '0;
      #1;
      chk("fl pre beat", 64'(beat_cnt), 64'(7));
      chk("fl pre gvalid", 64'(gon_valid), 64'(1));
      flush = 1'b1; pe_valid = 4'b0001; gon_ready = 1'b1;
      #1;
      chk("fl cycle ready", 64'(pe_ready), 64'(0));
      step();
      flush = 1'b0; pe_valid = '0; gon_ready = 1'b0;
      #1;
      chk("fl post gvalid", 64'(gon_valid), 64'(0));
      chk("fl post beat", 64'(beat_cnt), 64'(0));
      pe_valid = 4'b0001;
      #1;
      chk("fl ids kept", 64'(pe_ready), 64'(4'b0001));

      // Async reset mid-burst, off the clock edge
      pe_valid = 4'hF; tag_x = 5'd5; tag_y = 4'd0;
      step(); step();
      #3 rst_n = 1'b0;
      #1;
      chk("arst gvalid", 64'(gon_valid), 64'(0));
      chk("arst ready", 64'(pe_ready), 64'(0));
      chk("arst gdata", 64'(gon_data), 64'(0));
      chk("arst beat", 64'(beat_cnt), 64'(0));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      tag_x = 5'd0; tag_y = 4'd0;
      #1;
      chk("arst ids zero", 64'(pe_ready), 64'(4'b0001));
      tag_x = 5'd5;
      #1;
      chk("arst old ids gone", 64'(pe_ready), 64'(0));

      // Randomised traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         flush     = ($urandom_range(0, 15) == 0);
         set_xid   = ($urandom_range(0, 7) == 0);
         xid_in    = XW'($urandom_range(0, 3));
         set_yid   = ($urandom_range(0, 9) == 0);
         yid_in    = YW'($urandom_range(0, 1));
         tag_x     = XW'($urandom_range(0, 3));
         tag_y     = YW'($urandom_range(0, 1));
         pe_valid  = N'($urandom);
         gon_ready = $urandom_range(0, 1);
         for (int i = 0; i < N; i++) pe_data[i*DW +: DW] = $urandom;
         #1;
         check_model("rnd");
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
